// File: rtl/seq_detect_sched.sv
// seq_detect_sched: one serial pattern-match engine shared across NCH bit streams.
// A round-robin arbiter grants one requesting channel per cycle. That channel's
// saved history and fill count are advanced by the incoming bit and written back.
// A completed pattern is reported one cycle later, tagged with the channel id.
// Optional feature macro: SEQ_MATCH_CNT_EN adds saturating per-channel match
// counters with a combinational readout on cnt_rd. When the macro is not
// defined, cnt_rd is tied to zero.
module seq_detect_sched #(
  parameter int              NCH     = 4,
  parameter int              PLEN    = 4,
  parameter logic [PLEN-1:0] PATTERN = 4'b0110,
  parameter int              CW      = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int              CNTW    = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [NCH-1:0]  ch_valid,
  input  logic [NCH-1:0]  ch_bit,
  output logic [NCH-1:0]  ch_ready,
  input  logic [NCH-1:0]  clear_ch,
  output logic            match_valid,
  output logic [CW-1:0]   match_ch,
  input  logic [CW-1:0]   cnt_sel,
  output logic [CNTW-1:0] cnt_rd
);

  localparam int FW = $clog2(PLEN + 1);

  logic [PLEN-1:0] hist_q [NCH];
  logic [PLEN-1:0] hist_d [NCH];
  logic [FW-1:0]   fill_q [NCH];
  logic [FW-1:0]   fill_d [NCH];
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            match_valid_q, match_valid_d;
  logic [CW-1:0]   match_ch_q, match_ch_d;

  logic [NCH-1:0]  cand;
  logic [NCH-1:0]  grant;
  logic            gnt_any;
  logic [CW-1:0]   gnt_idx;
  logic [CW-1:0]   idx;
  logic [PLEN-1:0] nh;
  logic [FW-1:0]   nf;

`ifdef SEQ_MATCH_CNT_EN
  logic [CNTW-1:0] cnt_q [NCH];
  logic [CNTW-1:0] cnt_d [NCH];
`endif

  // A channel being cleared this cycle is never a grant candidate.
  assign cand = ch_valid & ~clear_ch;

  // Round-robin search starting at rr_ptr, wrapping modulo NCH; first candidate wins.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    if (reset_n && enable) begin
      for (int i = 0; i < NCH; i++) begin
        idx = CW'((int'(rr_ptr_q) + i) % NCH);
        if (!gnt_any && cand[idx]) begin
          grant[idx] = 1'b1;
          gnt_idx    = idx;
          gnt_any    = 1'b1;
        end
      end
    end
  end

  assign ch_ready = grant;

  // Context update for the granted channel, clears, match detect and pointer advance.
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    match_valid_d = 1'b0;
    match_ch_d    = match_ch_q;
    nh            = '0;
    nf            = '0;
    for (int k = 0; k < NCH; k++) begin
      hist_d[k] = hist_q[k];
      fill_d[k] = fill_q[k];
`ifdef SEQ_MATCH_CNT_EN
      cnt_d[k]  = cnt_q[k];
`endif
      if (clear_ch[k]) begin
        hist_d[k] = '0;
        fill_d[k] = '0;
`ifdef SEQ_MATCH_CNT_EN
        cnt_d[k]  = '0;
`endif
      end else if (grant[k]) begin
        nh = {hist_q[k][PLEN-2:0], ch_bit[k]};
        nf = (fill_q[k] == FW'(PLEN)) ? fill_q[k] : fill_q[k] + FW'(1);
        hist_d[k] = nh;
        fill_d[k] = nf;
        // Fill gate keeps zero-initialised history from faking a match.
        if ((nh == PATTERN) && (nf == FW'(PLEN))) begin
          match_valid_d = 1'b1;
          match_ch_d    = CW'(k);
`ifdef SEQ_MATCH_CNT_EN
          if (cnt_q[k] != {CNTW{1'b1}}) begin
            cnt_d[k] = cnt_q[k] + CNTW'(1);
          end
`endif
        end
      end
    end
    if (gnt_any) begin
      rr_ptr_d = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + CW'(1);
    end
  end

  // State registers; asynchronous reset discards every channel context.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NCH; k++) begin
        hist_q[k] <= '0;
        fill_q[k] <= '0;
      end
      rr_ptr_q      <= '0;
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        hist_q[k] <= hist_d[k];
        fill_q[k] <= fill_d[k];
      end
      rr_ptr_q      <= rr_ptr_d;
      match_valid_q <= match_valid_d;
      match_ch_q    <= match_ch_d;
    end
  end

  assign match_valid = match_valid_q;
  assign match_ch    = match_ch_q;

`ifdef SEQ_MATCH_CNT_EN
  // Match counters share the reset of the contexts they count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Out-of-range selects (NCH not a power of two) read as zero.
  always_comb begin
    cnt_rd = '0;
    if (int'(cnt_sel) < NCH) begin
      cnt_rd = cnt_q[cnt_sel];
    end
  end
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_rd         = '0;
`endif

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed testbench for seq_detect_sched (NCH=4, PLEN=4, PATTERN=0110, CNTW=2).
module tb_seq_detect_sched;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic [3:0] ch_valid;
  logic [3:0] ch_bit;
  logic [3:0] ch_ready;
  logic [3:0] clear_ch;
  logic       match_valid;
  logic [1:0] match_ch;
  logic [1:0] cnt_sel;
  logic [1:0] cnt_rd;

  int         vectors;
  int         miscompares;
  logic [3:0] rdy_s;
  logic [3:0] pat;

  seq_detect_sched #(
    .NCH(4), .PLEN(4), .PATTERN(4'b0110), .CW(2), .CNTW(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .ch_valid(ch_valid), .ch_bit(ch_bit), .ch_ready(ch_ready),
    .clear_ch(clear_ch), .match_valid(match_valid), .match_ch(match_ch),
    .cnt_sel(cnt_sel), .cnt_rd(cnt_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs, capture ch_ready before the edge, step past the edge.
  task automatic cyc(input logic [3:0] v, input logic [3:0] b, input logic [3:0] c);
    ch_valid = v;
    ch_bit   = b;
    clear_ch = c;
    #2;
    rdy_s = ch_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n  = 1'b0;
    ch_valid = '0;
    clear_ch = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    reset_n  = 1'b0;
    enable   = 1'b1;
    ch_valid = 4'b1111;
    cnt_sel  = 2'd3;
    #2;
    vectors++;
    if (ch_ready !== 4'b0000) begin
      $display("FAIL reset_ready: got %b want 0000", ch_ready);
      miscompares++;
    end
    @(posedge clk);
    #1;
    vectors++;
    if (match_valid !== 1'b0 || match_ch !== 2'd0 || cnt_rd !== 2'd0) begin
      $display("FAIL reset_outputs: mv=%b ch=%0d cnt=%0d want 0 0 0", match_valid, match_ch, cnt_rd);
      miscompares++;
    end
    ch_valid = '0;
    reset_n  = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] bits;
    bits = 4'b0110;
    do_reset();
    for (int j = 0; j < 4; j++) begin
      cyc(4'b0001, {3'b000, bits[3-j]}, 4'b0000);
      vectors++;
      if (rdy_s !== 4'b0001) begin
        $display("FAIL single_ready[%0d]: got %b want 0001", j, rdy_s);
        miscompares++;
      end
      vectors++;
      if (match_valid !== (j == 3)) begin
        $display("FAIL single_mv[%0d]: got %b want %b", j, match_valid, (j == 3));
        miscompares++;
      end
    end
    vectors++;
    if (match_ch !== 2'd0) begin
      $display("FAIL single_ch: got %0d want 0", match_ch);
      miscompares++;
    end
    cyc(4'b0000, 4'b0000, 4'b0000);
    vectors++;
    if (match_valid !== 1'b0) begin
      $display("FAIL single_pulse_width: got %b want 0", match_valid);
      miscompares++;
    end
  endtask

  task automatic test_overlap();
    logic [6:0] bits;
    logic [6:0] exp_mv;
    bits   = 7'b0110110;
    exp_mv = 7'b0001001;
    do_reset();
    for (int j = 0; j < 7; j++) begin
      cyc(4'b0001, {3'b000, bits[6-j]}, 4'b0000);
      vectors++;
      if (match_valid !== exp_mv[6-j]) begin
        $display("FAIL overlap_mv[%0d]: got %b want %b", j, match_valid, exp_mv[6-j]);
        miscompares++;
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      cyc(4'b1111, {4{pat[3 - c / 4]}}, 4'b0000);
      exp_rdy = 4'b0001 << (c % 4);
      vectors++;
      if (rdy_s !== exp_rdy) begin
        $display("FAIL rr_ready[%0d]: got %b want %b", c, rdy_s, exp_rdy);
        miscompares++;
      end
      vectors++;
      if (match_valid !== (c >= 12)) begin
        $display("FAIL rr_mv[%0d]: got %b want %b", c, match_valid, (c >= 12));
        miscompares++;
      end
      if (c >= 12) begin
        vectors++;
        if (match_ch !== 2'(c % 4)) begin
          $display("FAIL rr_ch[%0d]: got %0d want %0d", c, match_ch, c % 4);
          miscompares++;
        end
      end
    end
    cyc(4'b0000, 4'b0000, 4'b0000);
  endtask

  task automatic test_clear();
    do_reset();
    cyc(4'b0010, 4'b0000, 4'b0000);
    cyc(4'b0010, 4'b0010, 4'b0000);
    cyc(4'b0010, 4'b0010, 4'b0000);
    cyc(4'b0100, 4'b0000, 4'b0000);
    cyc(4'b0100, 4'b0100, 4'b0000);
    cyc(4'b0100, 4'b0100, 4'b0000);
    vectors++;
    if (match_valid !== 1'b0) begin
      $display("FAIL clear_premv: got %b want 0", match_valid);
      miscompares++;
    end
    // ch2 is cleared while valid; ch1 completes its pattern in the same cycle.
    cyc(4'b0110, 4'b0000, 4'b0100);
    vectors++;
    if (rdy_s !== 4'b0010) begin
      $display("FAIL clear_ready: got %b want 0010", rdy_s);
      miscompares++;
    end
    vectors++;
    if (match_valid !== 1'b1 || match_ch !== 2'd1) begin
      $display("FAIL clear_other_ch: mv=%b ch=%0d want 1 1", match_valid, match_ch);
      miscompares++;
    end
    cyc(4'b0100, 4'b0000, 4'b0000);
    vectors++;
    if (rdy_s !== 4'b0100 || match_valid !== 1'b0) begin
      $display("FAIL clear_after0: rdy=%b mv=%b want 0100 0", rdy_s, match_valid);
      miscompares++;
    end
    cyc(4'b0100, 4'b0100, 4'b0000);
    cyc(4'b0100, 4'b0100, 4'b0000);
    vectors++;
    if (match_valid !== 1'b0) begin
      $display("FAIL clear_partial: got %b want 0", match_valid);
      miscompares++;
    end
    cyc(4'b0100, 4'b0000, 4'b0000);
    vectors++;
    if (match_valid !== 1'b1 || match_ch !== 2'd2) begin
      $display("FAIL clear_complete: mv=%b ch=%0d want 1 2", match_valid, match_ch);
      miscompares++;
    end
    cyc(4'b0000, 4'b0000, 4'b0000);
  endtask

  task automatic test_reset_mid();
    do_reset();
    cnt_sel = 2'd3;
    for (int j = 0; j < 4; j++) cyc(4'b1000, {pat[3-j], 3'b000}, 4'b0000);
    vectors++;
    if (match_valid !== 1'b1 || match_ch !== 2'd3) begin
      $display("FAIL rmid_pre: mv=%b ch=%0d want 1 3", match_valid, match_ch);
      miscompares++;
    end
    cyc(4'b0010, 4'b0000, 4'b0000);
    cyc(4'b0010, 4'b0010, 4'b0000);
    cyc(4'b0010, 4'b0010, 4'b0000);
    reset_n  = 1'b0;
    ch_valid = 4'b0010;
    #2;
    vectors++;
    if (ch_ready !== 4'b0000 || match_valid !== 1'b0 || match_ch !== 2'd0 || cnt_rd !== 2'd0) begin
      $display("FAIL rmid_in_reset: rdy=%b mv=%b ch=%0d cnt=%0d want 0000 0 0 0",
               ch_ready, match_valid, match_ch, cnt_rd);
      miscompares++;
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc(4'b0010, 4'b0000, 4'b0000);
    vectors++;
    if (rdy_s !== 4'b0010 || match_valid !== 1'b0) begin
      $display("FAIL rmid_after: rdy=%b mv=%b want 0010 0", rdy_s, match_valid);
      miscompares++;
    end
  endtask

  task automatic test_counter();
    int n;
    do_reset();
    cnt_sel = 2'd3;
    n = 0;
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 4; j++) cyc(4'b1000, {pat[3-j], 3'b000}, 4'b0000);
      n++;
      vectors++;
      if (match_valid !== 1'b1) begin
        $display("FAIL cnt_mv[%0d]: got %b want 1", r, match_valid);
        miscompares++;
      end
      vectors++;
`ifdef SEQ_MATCH_CNT_EN
      if (cnt_rd !== 2'((n > 3) ? 3 : n)) begin
        $display("FAIL cnt_rd[%0d]: got %0d want %0d", r, cnt_rd, (n > 3) ? 3 : n);
        miscompares++;
      end
`else
      if (cnt_rd !== 2'd0) begin
        $display("FAIL cnt_tied[%0d]: got %0d want 0", r, cnt_rd);
        miscompares++;
      end
`endif
    end
    cyc(4'b0000, 4'b0000, 4'b0000);
  endtask

  task automatic test_enable();
    do_reset();
    cyc(4'b0001, 4'b0000, 4'b0000);
    enable = 1'b0;
    for (int j = 0; j < 2; j++) begin
      cyc(4'b1111, 4'b0000, 4'b0000);
      vectors++;
      if (rdy_s !== 4'b0000) begin
        $display("FAIL enable_off[%0d]: got %b want 0000", j, rdy_s);
        miscompares++;
      end
    end
    enable = 1'b1;
    cyc(4'b1111, 4'b0000, 4'b0000);
    vectors++;
    if (rdy_s !== 4'b0010) begin
      $display("FAIL enable_rr_hold: got %b want 0010", rdy_s);
      miscompares++;
    end
    cyc(4'b0000, 4'b0000, 4'b0000);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pat         = 4'b0110;
    reset_n     = 1'b0;
    enable      = 1'b1;
    ch_valid    = '0;
    ch_bit      = '0;
    clear_ch    = '0;
    cnt_sel     = '0;
    rdy_s       = '0;
    test_reset();
    test_single();
    test_overlap();
    test_round_robin();
    test_clear();
    test_reset_mid();
    test_counter();
    test_enable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
